cache_fill_fsm: RTL and testbench

//   Miss-handling controller between the pipeline's instruction/data caches and the

---
 rtl/cache_fill_fsm.sv | 107 ++++++++++
 tb/tb_cache_fill_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one read per word of the
// missed block from main memory into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WORD_BYTES      = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic [15:0]                        memory_data,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array
);

  // state | meaning
  // IDLE  | no fill in progress; a miss stalls combinationally and starts a fill
  // FILL  | issuing word reads and writing returned words into the data array
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK * WORD_BYTES);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_rcv_cnt;

  logic               w_issue_open;
  logic               w_rcv_take;
  logic               w_last;
  logic               w_capture;
  logic [ADDR_W-1:0]  w_rd_addr;

  assign w_issue_open = (r_issue_cnt < CNT_FULL);
  assign w_rcv_take   = memory_data_valid && (r_rcv_cnt < CNT_FULL);
  assign w_last       = w_rcv_take && (r_rcv_cnt == CNT_LAST);
  assign w_rd_addr    = r_base + ADDR_W'(r_issue_cnt) * ADDR_W'(WORD_BYTES);

  // A miss seen in the completion cycle chains straight into the next fill.
  assign w_capture = !rst && miss_detected &&
                     ((r_state == IDLE) || (r_state == FILL && w_last));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          fsm_busy = miss_detected;
          if (miss_detected) w_state_nxt = FILL;
        end
        FILL: begin
          fsm_busy         = 1'b1;
          mem_rd_en        = w_issue_open;
          memory_address   = w_issue_open ? w_rd_addr : '0;
          write_data_array = w_rcv_take;
          word_index       = w_rcv_take ? r_rcv_cnt[IDX_W-1:0] : '0;
          write_tag_array  = w_last;
          if (w_last) w_state_nxt = miss_detected ? FILL : IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign fill_data = rst ? 16'h0000 : memory_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
    end else if (w_capture) begin
      r_base      <= miss_address & BASE_MASK;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
    end else if (r_state == FILL) begin
      if (w_issue_open) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_rcv_take)   r_rcv_cnt   <= r_rcv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: reset, single fills, ignored misses,
// back-to-back chaining, reset abort with address wrap, and gapped returns.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int n_checks = 0;
  int n_errors = 0;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .WORD_BYTES(2)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change just after the falling edge; outputs sampled 1 ns later
  task automatic drive(input logic r, input logic m, input logic [15:0] ma,
                       input logic v, input logic [15:0] md);
    @(negedge clk);
    rst               = r;
    miss_detected     = m;
    miss_address      = ma;
    memory_data_valid = v;
    memory_data       = md;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic busy, input logic rd,
                          input logic [15:0] addr, input logic wda, input logic [2:0] idx,
                          input logic tagw, input logic [15:0] fd);
    chk_val({tag, ".busy"}, 32'(fsm_busy), 32'(busy));
    chk_val({tag, ".rd"},   32'(mem_rd_en), 32'(rd));
    chk_val({tag, ".addr"}, 32'(memory_address), 32'(addr));
    chk_val({tag, ".wda"},  32'(write_data_array), 32'(wda));
    chk_val({tag, ".idx"},  32'(word_index), 32'(idx));
    chk_val({tag, ".tag"},  32'(write_tag_array), 32'(tagw));
    chk_val({tag, ".fd"},   32'(fill_data), 32'(fd));
  endtask

  // One fill with memory latency 4: miss in cycle 0, reads 1..8, returns 5..12.
  task automatic fill_run(input string tag, input logic [15:0] maddr,
                          input logic [15:0] base, input bit noise);
    for (int c = 0; c <= 13; c++) begin
      logic        m;
      logic [15:0] ma;
      logic        v;
      logic [15:0] md;
      logic        e_rd;
      logic [15:0] e_addr;
      logic [2:0]  e_idx;
      m  = (c == 0) || (noise && (c == 3 || c == 6 || c == 9));
      ma = (c == 0) ? maddr : 16'h5000;
      v  = (c >= 5) && (c <= 12);
      md = v ? 16'(16'hA000 + c) : 16'h0000;
      drive(1'b0, m, ma, v, md);
      e_rd   = (c >= 1) && (c <= 8);
      e_addr = e_rd ? 16'(base + 2 * (c - 1)) : 16'h0000;
      e_idx  = v ? 3'(c - 5) : 3'd0;
      chk_outs($sformatf("%s.c%0d", tag, c), (c <= 12), e_rd, e_addr, v, e_idx,
               (c == 12), md);
    end
  endtask

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data = 16'h0; memory_data_valid = 1'b0;

    // reset dominates miss and valid
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 16'h1234, 1'b1, 16'hFFFF);
      chk_outs($sformatf("rst.c%0d", c), 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
    chk_outs("idle", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_outs("idle2", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);

    fill_run("fill", 16'h1234, 16'h1230, 1'b0);
    fill_run("noise", 16'h1234, 16'h1230, 1'b1);

    // miss held through completion: second block 0x2000 chains without a bubble
    for (int c = 0; c <= 25; c++) begin
      logic        v;
      logic        e_rd;
      logic [15:0] e_addr;
      logic [2:0]  e_idx;
      v = ((c >= 5) && (c <= 12)) || ((c >= 17) && (c <= 24));
      drive(1'b0, (c <= 12), (c == 0) ? 16'h1234 : 16'h2008, v, v ? 16'(c) : 16'h0);
      e_rd   = ((c >= 1) && (c <= 8)) || ((c >= 13) && (c <= 20));
      e_addr = ((c >= 1) && (c <= 8)) ? 16'(16'h1230 + 2 * (c - 1)) :
               ((c >= 13) && (c <= 20)) ? 16'(16'h2000 + 2 * (c - 13)) : 16'h0;
      e_idx  = !v ? 3'd0 : (c <= 12) ? 3'(c - 5) : 3'(c - 17);
      chk_outs($sformatf("b2b.c%0d", c), (c <= 24), e_rd, e_addr, v, e_idx,
               (c == 12) || (c == 24), v ? 16'(c) : 16'h0);
    end

    // reset after three returns aborts the fill; stray valids are dropped
    for (int c = 0; c <= 12; c++) begin
      logic        r;
      logic        v;
      logic [15:0] md;
      logic        e_rd;
      logic        e_wda;
      r  = (c == 8);
      v  = (c >= 5);
      md = v ? 16'(16'hB000 + c) : 16'h0;
      drive(r, (c == 0), 16'h1234, v, md);
      e_rd  = (c >= 1) && (c <= 7);
      e_wda = (c >= 5) && (c <= 7);
      chk_outs($sformatf("abort.c%0d", c), (c <= 7), e_rd,
               e_rd ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0, e_wda,
               e_wda ? 3'(c - 5) : 3'd0, 1'b0, r ? 16'h0 : md);
    end
    fill_run("wrap", 16'hFFFE, 16'hFFF0, 1'b0);

    // randomly gapped returns
    begin
      int t;
      int k;
      int n_wr;
      int n_tag;
      t = 0; k = 0; n_wr = 0; n_tag = 0;
      drive(1'b0, 1'b1, 16'h0105, 1'b0, 16'h0);
      chk_val("gap.busy0", 32'(fsm_busy), 32'd1);
      t = 1;
      drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      chk_val("gap.rd1", 32'(mem_rd_en), 32'd1);
      chk_val("gap.addr1", 32'(memory_address), 32'h0100);
      while (k < 8) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int i = 0; i <= g; i++) begin
          logic v;
          t++;
          v = (i == g);
          drive(1'b0, 1'b0, 16'h0, v, 16'(16'hC000 + k));
          chk_val($sformatf("gap.t%0d.busy", t), 32'(fsm_busy), 32'd1);
          chk_val($sformatf("gap.t%0d.rd", t), 32'(mem_rd_en), 32'(t <= 8));
          if (t <= 8)
            chk_val($sformatf("gap.t%0d.addr", t), 32'(memory_address),
                    32'(16'h0100 + 2 * (t - 1)));
          chk_val($sformatf("gap.t%0d.wda", t), 32'(write_data_array), 32'(v));
          chk_val($sformatf("gap.t%0d.tag", t), 32'(write_tag_array), 32'(v && k == 7));
          if (v) begin
            chk_val($sformatf("gap.t%0d.idx", t), 32'(word_index), 32'(k));
            k++;
          end
          n_wr  += int'(write_data_array);
          n_tag += int'(write_tag_array);
        end
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
      n_wr  += int'(write_data_array);
      n_tag += int'(write_tag_array);
      chk_val("gap.busy_end", 32'(fsm_busy), 32'd0);
      chk_val("gap.n_wr", 32'(n_wr), 32'd8);
      chk_val("gap.n_tag", 32'(n_tag), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
